// File: rtl/rv32i_io_pad_arbiter_if.sv
// Request/pad bundle between the GPIO pad requesters and the round-robin pad arbiter.
interface rv32i_io_pad_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 16
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      pad_out;
  logic [WIDTH-1:0]      pad_oeb;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  modport master (output req, req_data, input ack, pad_out, pad_oeb, grant_id, busy);
  modport slave  (input req, req_data, output ack, pad_out, pad_oeb, grant_id, busy);
endinterface

// File: rtl/rv32i_io_pad_arbiter.sv
// Round-robin owner of the user GPIO pad group: drive a granted word for HOLD cycles,
// then tri-state the pads for TURN cycles before the next grant.
module rv32i_io_pad_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 16,
  parameter int HOLD  = 4,
  parameter int TURN  = 1
) (
  input logic               clk,
  input logic               RN,
  rv32i_io_pad_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MX = (HOLD > TURN) ? HOLD : TURN;
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    hold_cnt, hold_nxt, turn_cnt, turn_nxt;
  logic [GW-1:0]    rr_ptr, rr_nxt, gid, gid_nxt, win;
  logic             found;
  logic [WIDTH-1:0] pout, pout_nxt;
  logic             oeb, oeb_nxt;
  logic [NREQ-1:0]  ack_r, ack_nxt;
  logic             busy_r, busy_nxt;

  // First set request scanning upward from rr_ptr, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[GW'((int'(rr_ptr) + i) % NREQ)]) begin
        found = 1'b1;
        win   = GW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    rr_nxt    = rr_ptr;
    gid_nxt   = gid;
    pout_nxt  = pout;
    oeb_nxt   = oeb;
    ack_nxt   = '0;
    case (state)
      S_IDLE: if (found) begin
        gid_nxt   = win;
        pout_nxt  = bus.req_data[int'(win)*WIDTH +: WIDTH];
        oeb_nxt   = 1'b0;
        hold_nxt  = CW'(HOLD - 1);
        state_nxt = S_DRIVE;
        if (HOLD == 1) ack_nxt[win] = 1'b1;
      end
      S_DRIVE: begin
        if (hold_cnt == '0) begin
          oeb_nxt   = 1'b1;
          rr_nxt    = (gid == GW'(NREQ - 1)) ? '0 : gid + 1'b1;
          turn_nxt  = CW'(TURN - 1);
          state_nxt = S_TURN;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
          // ack is registered, so raise it one cycle ahead of the last drive cycle
          if (hold_cnt == CW'(1)) ack_nxt[gid] = 1'b1;
        end
      end
      S_TURN: begin
        if (turn_cnt == '0) state_nxt = S_IDLE;
        else                turn_nxt  = turn_cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      turn_cnt <= '0;
      rr_ptr   <= '0;
      gid      <= '0;
      pout     <= '0;
      oeb      <= 1'b1;
      ack_r    <= '0;
      busy_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      rr_ptr   <= rr_nxt;
      gid      <= gid_nxt;
      pout     <= pout_nxt;
      oeb      <= oeb_nxt;
      ack_r    <= ack_nxt;
      busy_r   <= busy_nxt;
    end
  end

  // A single enable bit fanned out keeps the pad group all-driven or all-released.
  assign bus.pad_oeb  = {WIDTH{oeb}};
  assign bus.pad_out  = pout;
  assign bus.grant_id = gid;
  assign bus.ack      = ack_r;
  assign bus.busy     = busy_r;
endmodule

// File: tb/tb_rv32i_io_pad_arbiter.sv
// Randomized bench for the pad arbiter: a timing-level reference model feeds a scoreboard queue.
module tb_rv32i_io_pad_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 16;
  localparam int HOLD = 4;
  localparam int TURN = 1;

  typedef struct {
    int          id;
    logic [W-1:0] data;
    int          g;
  } xfer_t;

  logic clk, RN;
  rv32i_io_pad_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  rv32i_io_pad_arbiter #(.NREQ(NREQ), .WIDTH(W), .HOLD(HOLD), .TURN(TURN)) dut (
    .clk(clk), .RN(RN), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  xfer_t q[$];
  int    n_cmp = 0, n_bad = 0;
  int    last_g = -100;
  int    m_rr = 0, m_free_at = 0;
  bit    want_rst = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_n, act, exp);
    end
  endtask

  // Reference: a grant can only happen at an edge where the pads have been free long enough;
  // the winner is the first requester at or after the round-robin pointer.
  task automatic model_step();
    int e;
    e = edge_n + 1;
    if (e >= m_free_at && bus.req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int id;
        id = (m_rr + k) % NREQ;
        if (bus.req[id]) begin
          q.push_back('{id, bus.req_data[id*W +: W], e});
          m_rr      = (id + 1) % NREQ;
          m_free_at = e + HOLD + TURN + 1;
          break;
        end
      end
    end
  endtask

  task automatic rand_reqs();
    logic [W-1:0] d;
    for (int i = 0; i < NREQ; i++) begin
      d = W'($urandom);
      if (bus.ack[i]) begin
        if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
        else                        bus.req_data[i*W +: W] = d;
      end else if (!bus.req[i]) begin
        if ($urandom_range(2) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_data[i*W +: W] = d;
        end
      end else begin
        if ($urandom_range(3) == 0) bus.req_data[i*W +: W] = d;
        if (bus.busy && int'(bus.grant_id) == i && bus.pad_oeb == '0 && $urandom_range(7) == 0)
          bus.req[i] = 1'b0;
      end
    end
  endtask

  // Asynchronous reset asserted between edges: outputs must clear before any clock.
  task automatic do_reset();
    RN = 1'b1;
    #1;
    chk("rst_oeb",  32'(bus.pad_oeb),  32'hFFFF);
    chk("rst_pad",  32'(bus.pad_out),  32'h0);
    chk("rst_ack",  32'(bus.ack),      32'h0);
    chk("rst_busy", 32'(bus.busy),     32'h0);
    chk("rst_gid",  32'(bus.grant_id), 32'h0);
    q.delete();
    last_g    = -100;
    m_rr      = 0;
    m_free_at = 0;
    @(negedge clk); #2;
    RN = 1'b0;
  endtask

  // Monitor: compares every cycle's pad state against the scoreboard front.
  logic            exp_drv, exp_busy;
  logic [NREQ-1:0] exp_ack;
  always @(negedge clk) begin
    if (!RN) begin
      exp_drv  = (q.size() > 0) && (edge_n >= q[0].g);
      exp_busy = exp_drv || (edge_n <= last_g + HOLD + TURN - 1);
      exp_ack  = '0;
      chk("oeb",  32'(bus.pad_oeb), exp_drv ? 32'h0 : 32'hFFFF);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      if (exp_drv) begin
        chk("pad_out",  32'(bus.pad_out),  32'(q[0].data));
        chk("grant_id", 32'(bus.grant_id), 32'(q[0].id));
        if (edge_n == q[0].g + HOLD - 1) exp_ack[q[0].id] = 1'b1;
      end
      chk("ack", 32'(bus.ack), 32'(exp_ack));
      if (exp_ack != '0) begin
        last_g = q[0].g;
        void'(q.pop_front());
      end
    end
  end

  initial begin
    RN = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    @(negedge clk); #2;
    chk("init_oeb",  32'(bus.pad_oeb), 32'hFFFF);
    chk("init_busy", 32'(bus.busy),    32'h0);
    RN = 1'b0;

    // single requester, fixed word
    bus.req = 3'b001;
    bus.req_data[0 +: W] = 16'hA5A5;
    model_step();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #2;
      if (bus.ack[0]) bus.req[0] = 1'b0;
      if (c == 1) bus.req_data[0 +: W] = 16'hFF00;
      model_step();
    end

    // all three requesting continuously
    bus.req_data = {16'h3333, 16'h2222, 16'h1111};
    bus.req = 3'b111;
    model_step();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #2;
      model_step();
    end

    // randomized traffic with occasional reset in the middle of a drive window
    for (int it = 0; it < 2500; it++) begin
      @(negedge clk); #2;
      if (it % 400 == 200) want_rst = 1'b1;
      if (want_rst && bus.pad_oeb == '0) begin
        want_rst = 1'b0;
        do_reset();
      end
      rand_reqs();
      model_step();
    end

    bus.req = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #2;
      model_step();
    end
    chk("drain", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
